// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : start/busy/done handshake and operand/result bundle for the
//            bit-serial subtractor.
// Revision : 1.0
// ============================================================================
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : LSB-first bit-serial a - b - bin using one full-subtractor cell
//            and a borrow flop behind a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   // One-hot so busy/done come straight off state flops.
   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      SHIFT = 3'b010,
      DONE  = 3'b100
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic [WIDTH-1:0] w_res_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_br;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_bout;
   logic             r_ovf;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_last;
   logic             w_accept;
   logic             w_busy;
   logic             w_done;

   assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
   assign w_br_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

   generate
      if (WIDTH == 1) begin : g_w1
         assign w_res_nxt = w_d;
      end else begin : g_wn
         assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            w_busy = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = bus.start ? SHIFT : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_res   <= '0;
         r_diff  <= '0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_bout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_sa    <= bus.a;
         r_sb    <= bus.b;
         r_br    <= bus.bin;
         r_a_msb <= bus.a[WIDTH-1];
         r_b_msb <= bus.b[WIDTH-1];
         r_res   <= '0;
         r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
         r_sa  <= r_sa >> 1;
         r_sb  <= r_sb >> 1;
         r_br  <= w_br_nxt;
         r_res <= w_res_nxt;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            // The bit processed now is the result MSB, so w_d drives ovf.
            r_diff <= w_res_nxt;
            r_bout <= w_br_nxt;
            r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.diff = r_diff;
   assign bus.bout = r_bout;
   assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed table plus corner sequences at WIDTH=8, full sweep at 4.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] ed;
      logic       eb;
      logic       eo;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [7:0] a,
                        input logic [7:0] b, input logic bin);
      if (sel == 8) begin
         bus8.start = st; bus8.a = a; bus8.b = b; bus8.bin = bin;
      end else begin
         bus4.start = st; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.bin = bin;
      end
   endtask

   task automatic sample(input int sel, output logic dn, output logic bs,
                         output logic [7:0] df, output logic bo, output logic ov);
      if (sel == 8) begin
         dn = bus8.done; bs = bus8.busy; df = bus8.diff; bo = bus8.bout; ov = bus8.ovf;
      end else begin
         dn = bus4.done; bs = bus4.busy; df = {4'b0, bus4.diff}; bo = bus4.bout; ov = bus4.ovf;
      end
   endtask

   // Counts negedges until done is seen; 0 means it never came.
   task automatic wait_done(input int sel, output int lat);
      logic       dn, bs, bo, ov;
      logic [7:0] df;
      int         k;
      lat = 0;
      k   = 0;
      while (lat == 0 && k < 40) begin
         k++;
         @(negedge clk);
         sample(sel, dn, bs, df, bo, ov);
         if (dn) lat = k;
      end
   endtask

   task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic eb,
                         input logic eo, input string nm);
      logic       dn, bs, bo, ov;
      logic [7:0] df;
      int         lat;
      @(negedge clk);
      drive(sel, 1'b1, a, b, bin);
      @(posedge clk);
      #1 drive(sel, 1'b0, ~a, ~b, ~bin);
      wait_done(sel, lat);
      chk({nm, " latency"}, lat, sel + 1);
      sample(sel, dn, bs, df, bo, ov);
      chk({nm, " diff"}, df, ed);
      chk({nm, " bout"}, bo, eb);
      chk({nm, " ovf"}, ov, eo);
      @(negedge clk);
      sample(sel, dn, bs, df, bo, ov);
      chk({nm, " done one cycle"}, dn, 0);
      chk({nm, " diff held"}, df, ed);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic       dn, bs, bo, ov;
      logic [7:0] df;
      int         lat;
      int         cnt;
      int         sa, sb, res;

      vecs[0] = '{8'd5,   8'd3,   1'b0, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'd3,   8'd5,   1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h7F,  8'hFF,  1'b0, 8'h80, 1'b1, 1'b1};
      vecs[5] = '{8'hFF,  8'hFF,  1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h80,  8'h00,  1'b1, 8'h7F, 1'b0, 1'b1};
      vecs[7] = '{8'd200, 8'd100, 1'b0, 8'd100, 1'b0, 1'b1};

      rst = 1'b0;
      drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
      drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      sample(8, dn, bs, df, bo, ov);
      chk("reset busy", bs, 0);
      chk("reset done", dn, 0);
      chk("reset diff", df, 0);
      chk("reset bout", bo, 0);
      chk("reset ovf", ov, 0);
      rst = 1'b1;

      for (int i = 0; i < 8; i++)
         run_op(8, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb,
                vecs[i].eo, $sformatf("vec%0d", i));

      // Start during SHIFT is ignored; start held in DONE chains immediately.
      @(negedge clk);
      drive(8, 1'b1, 8'd10, 8'd4, 1'b0);
      @(posedge clk);
      #1 drive(8, 1'b0, 8'd10, 8'd4, 1'b0);
      @(negedge clk);
      sample(8, dn, bs, df, bo, ov);
      chk("busy in shift", bs, 1);
      @(negedge clk);
      @(negedge clk);
      drive(8, 1'b1, 8'd99, 8'd4, 1'b0);
      @(negedge clk);
      drive(8, 1'b0, 8'd99, 8'd4, 1'b0);
      wait_done(8, lat);
      chk("protect latency", lat, 5);
      sample(8, dn, bs, df, bo, ov);
      chk("protect diff", df, 6);
      chk("busy low in done", bs, 0);
      drive(8, 1'b1, 8'd20, 8'd7, 1'b0);
      @(posedge clk);
      #1 drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
      wait_done(8, lat);
      chk("b2b latency", lat, 9);
      sample(8, dn, bs, df, bo, ov);
      chk("b2b diff", df, 13);
      chk("b2b bout", bo, 0);
      chk("b2b ovf", ov, 0);

      // Asynchronous abort mid-SHIFT.
      @(negedge clk);
      drive(8, 1'b1, 8'd50, 8'd20, 1'b0);
      @(posedge clk);
      #1 drive(8, 1'b0, 8'd50, 8'd20, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1 sample(8, dn, bs, df, bo, ov);
      chk("abort busy", bs, 0);
      chk("abort done", dn, 0);
      chk("abort diff", df, 0);
      chk("abort bout", bo, 0);
      chk("abort ovf", ov, 0);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         sample(8, dn, bs, df, bo, ov);
         if (dn) cnt++;
      end
      chk("no done after abort", cnt, 0);
      run_op(8, 8'd200, 8'd100, 1'b0, 8'd100, 1'b0, 1'b1, "post abort");

      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               sa  = (ia > 7) ? ia - 16 : ia;
               sb  = (ib > 7) ? ib - 16 : ib;
               res = sa - sb - ic;
               run_op(4, 8'(ia), 8'(ib), 1'(ic), 8'((ia - ib - ic) & 15),
                      (ia < ib + ic), (res < -8) || (res > 7),
                      $sformatf("w4 %0d-%0d-%0d", ia, ib, ic));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
